// File: rtl/graphics_pkg.sv
// Shared screen-space geometry types for the vertex-to-raster front end.
// Latency: none, types and pure functions only.
// Backpressure: not applicable.
package graphics_pkg;

  typedef logic [16:0] coord_t;
  typedef coord_t [1:0] vertex_t;  // [0]=x, [1]=y

  typedef struct packed {
    vertex_t [2:0] vertices;
    logic [33:0]   area;
    vertex_t       bbox_min;
    vertex_t       bbox_max;
    logic          flipped;
  } setup_t;

  localparam int AREA_LATENCY = 6;

  function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/setup_fifo.sv
// First-word-fall-through FIFO of setup results with an occupancy count.
// Latency: one cycle from push to the entry appearing at the head.
// Backpressure: caller guarantees no push when full without a same-cycle pop.
module setup_fifo
  import graphics_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   push_in,
  input  setup_t                 push_dat_in,
  input  logic                   pop_in,
  output setup_t                 pop_dat_out,
  output logic [$clog2(DEPTH):0] count_out
);

  localparam int AW = $clog2(DEPTH);

  setup_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  // Pointers wrap naturally because DEPTH is a power of two; empty pops are ignored.
  always_comb begin
    do_pop   = pop_in && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(push_in);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(push_in) - (AW+1)'(do_pop);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk_in) begin
    if (push_in) mem_q[wr_ptr_q] <= push_dat_in;
  end

  assign pop_dat_out = mem_q[rd_ptr_q];
  assign count_out   = count_q;

endmodule

// File: rtl/triangle_area.sv
// Doubled signed triangle area: |(x2-x0)(y1-y0) - (x1-x0)(y2-y0)| plus sign.
// Latency: fixed AREA_LATENCY (6) cycles from valid_in to valid_out.
// Backpressure: none; the pipeline never stalls, callers must budget for results.
module triangle_area
  import graphics_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          valid_in,
  input  vertex_t [2:0] vertices_in,
  output logic          valid_out,
  output logic [33:0]   area_out,
  output logic          negative_out
);

  logic [5:0]         vld_q, vld_d;
  logic signed [17:0] dif_q [4];
  logic signed [17:0] dif_d [4];
  logic signed [35:0] prod_q [2];
  logic signed [35:0] prod_d [2];
  logic signed [36:0] cross_q, cross_d;
  logic [34:0]        res_q [3];  // {negative, magnitude}
  logic [34:0]        res_d [3];
  logic [33:0]        mag;

  // Edge vectors, products, cross product, then sign/magnitude and two delay stages.
  always_comb begin
    vld_d = {vld_q[4:0], valid_in};
    dif_d[0] = $signed({1'b0, vertices_in[2][0]}) - $signed({1'b0, vertices_in[0][0]});
    dif_d[1] = $signed({1'b0, vertices_in[1][1]}) - $signed({1'b0, vertices_in[0][1]});
    dif_d[2] = $signed({1'b0, vertices_in[1][0]}) - $signed({1'b0, vertices_in[0][0]});
    dif_d[3] = $signed({1'b0, vertices_in[2][1]}) - $signed({1'b0, vertices_in[0][1]});
    prod_d[0] = 36'(dif_q[0]) * 36'(dif_q[1]);
    prod_d[1] = 36'(dif_q[2]) * 36'(dif_q[3]);
    cross_d   = 37'(prod_q[0]) - 37'(prod_q[1]);
    mag       = cross_q[36] ? 34'(-cross_q) : 34'(cross_q);
    res_d[0]  = {cross_q[36], mag};
    res_d[1]  = res_q[0];
    res_d[2]  = res_q[1];
  end

  // Only the valid chain needs reset; data stages simply follow it.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) vld_q <= '0;
    else           vld_q <= vld_d;
    dif_q   <= dif_d;
    prod_q  <= prod_d;
    cross_q <= cross_d;
    res_q   <= res_d;
  end

  assign valid_out    = vld_q[5];
  assign area_out     = res_q[2][33:0];
  assign negative_out = res_q[2][34];

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: cull, CCW-normalise and bbox-clamp triangles ahead of the rasterizer.
// Latency: 8 cycles accept-to-output with an empty FIFO; 1 triangle/cycle throughput.
// Backpressure: credit-based, ready only while in-flight + queued < FIFO_DEPTH; optional
// cull/emit counters under TRIANGLE_SETUP_STATS_EN.
module triangle_setup
  import graphics_pkg::*;
#(
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int CULL_BACK  = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  tri_valid_in,
  output logic                  tri_ready_out,
  input  logic [2:0][1:0][16:0] vertices_in,
  output logic                  tri_valid_out,
  input  logic                  tri_ready_in,
  output logic [2:0][1:0][16:0] vertices_out,
  output logic [33:0]           area_out,
  output logic [1:0][16:0]      bbox_min_out,
  output logic [1:0][16:0]      bbox_max_out,
`ifdef TRIANGLE_SETUP_STATS_EN
  output logic [31:0]           culled_zero_out,
  output logic [31:0]           culled_back_out,
  output logic [31:0]           culled_offscreen_out,
  output logic [31:0]           emitted_out,
`endif
  output logic                  flipped_out
);

  localparam int      CW  = $clog2(FIFO_DEPTH) + 1;
  localparam vertex_t LIM = {coord_t'(SCREEN_H - 1), coord_t'(SCREEN_W - 1)};

  logic          accept, area_vld, area_neg, is_zero, is_back, is_off, push, pop;
  logic [33:0]   area;
  logic [CW-1:0] in_flight_q, in_flight_d, fifo_count;
  logic [CW:0]   credit_sum;
  vertex_t [2:0] dly_q [AREA_LATENCY];
  vertex_t [2:0] dly_d [AREA_LATENCY];
  logic          dec_vld_q, dec_vld_d, dec_neg_q, dec_neg_d;
  logic [33:0]   dec_area_q, dec_area_d;
  vertex_t [2:0] dec_vtx_q, dec_vtx_d;
  vertex_t       raw_min, raw_max;
  setup_t        push_dat, pop_dat, out_dat;

  assign credit_sum    = {1'b0, in_flight_q} + {1'b0, fifo_count};
  assign tri_ready_out = rst_n_in && (credit_sum < (CW+1)'(FIFO_DEPTH));
  assign accept        = tri_valid_in && tri_ready_out;

  triangle_area u_area (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .valid_in     (accept),
    .vertices_in  (vertices_in),
    .valid_out    (area_vld),
    .area_out     (area),
    .negative_out (area_neg)
  );

  // Vertex delay line aligned with the area pipeline, decision-stage capture, credit count.
  always_comb begin
    dly_d[0] = vertices_in;
    for (int i = 1; i < AREA_LATENCY; i++) dly_d[i] = dly_q[i-1];
    dec_vld_d   = area_vld;
    dec_neg_d   = area_neg;
    dec_area_d  = area;
    dec_vtx_d   = dly_q[AREA_LATENCY-1];
    in_flight_d = in_flight_q + CW'(accept) - CW'(dec_vld_q);
  end

  // Decision: cull tests on the unclipped bbox, winding swap, clamp, FIFO push.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      raw_min[a] = min3(dec_vtx_q[0][a], dec_vtx_q[1][a], dec_vtx_q[2][a]);
      raw_max[a] = max3(dec_vtx_q[0][a], dec_vtx_q[1][a], dec_vtx_q[2][a]);
    end
    is_zero = (dec_area_q == '0);
    is_back = dec_neg_q && (CULL_BACK != 0);
    is_off  = (raw_min[0] > LIM[0]) || (raw_min[1] > LIM[1]);
    push    = dec_vld_q && !(is_zero || is_back || is_off);
    push_dat.vertices[0] = dec_vtx_q[0];
    push_dat.vertices[1] = dec_neg_q ? dec_vtx_q[2] : dec_vtx_q[1];
    push_dat.vertices[2] = dec_neg_q ? dec_vtx_q[1] : dec_vtx_q[2];
    push_dat.area        = dec_area_q;
    push_dat.flipped     = dec_neg_q;
    for (int a = 0; a < 2; a++) begin
      push_dat.bbox_min[a] = (raw_min[a] > LIM[a]) ? LIM[a] : raw_min[a];
      push_dat.bbox_max[a] = (raw_max[a] > LIM[a]) ? LIM[a] : raw_max[a];
    end
  end

  // Pipeline state; only valid/count flops need reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      dec_vld_q   <= 1'b0;
      in_flight_q <= '0;
    end else begin
      dec_vld_q   <= dec_vld_d;
      in_flight_q <= in_flight_d;
    end
    dly_q      <= dly_d;
    dec_neg_q  <= dec_neg_d;
    dec_area_q <= dec_area_d;
    dec_vtx_q  <= dec_vtx_d;
  end

  setup_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .push_in     (push),
    .push_dat_in (push_dat),
    .pop_in      (pop),
    .pop_dat_out (pop_dat),
    .count_out   (fifo_count)
  );

  assign tri_valid_out = rst_n_in && (fifo_count != '0);
  assign pop           = tri_valid_out && tri_ready_in;
  assign out_dat       = tri_valid_out ? pop_dat : '0;
  assign vertices_out  = out_dat.vertices;
  assign area_out      = out_dat.area;
  assign bbox_min_out  = out_dat.bbox_min;
  assign bbox_max_out  = out_dat.bbox_max;
  assign flipped_out   = out_dat.flipped;

`ifdef TRIANGLE_SETUP_STATS_EN
  logic [31:0] cnt_zero_q, cnt_zero_d, cnt_back_q, cnt_back_d;
  logic [31:0] cnt_off_q, cnt_off_d, cnt_emit_q, cnt_emit_d;

  // One event per decided triangle; precedence zero > back > offscreen.
  always_comb begin
    cnt_zero_d = cnt_zero_q;
    cnt_back_d = cnt_back_q;
    cnt_off_d  = cnt_off_q;
    cnt_emit_d = cnt_emit_q;
    if (dec_vld_q) begin
      if (is_zero)      cnt_zero_d = sat_inc(cnt_zero_q);
      else if (is_back) cnt_back_d = sat_inc(cnt_back_q);
      else if (is_off)  cnt_off_d  = sat_inc(cnt_off_q);
      else              cnt_emit_d = sat_inc(cnt_emit_q);
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt_zero_q <= '0;
      cnt_back_q <= '0;
      cnt_off_q  <= '0;
      cnt_emit_q <= '0;
    end else begin
      cnt_zero_q <= cnt_zero_d;
      cnt_back_q <= cnt_back_d;
      cnt_off_q  <= cnt_off_d;
      cnt_emit_q <= cnt_emit_d;
    end
  end

  assign culled_zero_out      = cnt_zero_q;
  assign culled_back_out      = cnt_back_q;
  assign culled_offscreen_out = cnt_off_q;
  assign emitted_out          = cnt_emit_q;
`endif

endmodule

// File: tb/tb_triangle_setup.sv
// Scoreboard bench for triangle_setup: two instances (back-face cull on and off) share stimulus.
// Expected results come from a behavioural model at accept time and are popped at output.
// Downstream readiness is driven directly to exercise credit backpressure.
module tb_triangle_setup;
  import graphics_pkg::*;

  typedef logic [2:0][1:0][16:0] tri_t;

  localparam int SW = 320;
  localparam int SH = 240;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        tri_valid_in = 1'b0;
  logic        tri_ready_in = 1'b0;
  tri_t        vertices_in = '0;
  logic        rdy_o [2];
  logic        vld_o [2];
  tri_t        vout [2];
  logic [33:0] area_o [2];
  logic [1:0][16:0] bmin_o [2];
  logic [1:0][16:0] bmax_o [2];
  logic        flip_o [2];
`ifdef TRIANGLE_SETUP_STATS_EN
  logic [31:0] st_zero [2];
  logic [31:0] st_back [2];
  logic [31:0] st_off [2];
  logic [31:0] st_emit [2];
`endif

  int n_tests = 0;
  int n_fail = 0;
  int acc_cnt [2];
  setup_t sb0 [$];
  setup_t sb1 [$];

  always #5 clk_in = ~clk_in;

  triangle_setup #(.CULL_BACK(1)) u_dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .tri_valid_in(tri_valid_in), .tri_ready_out(rdy_o[0]), .vertices_in(vertices_in),
    .tri_valid_out(vld_o[0]), .tri_ready_in(tri_ready_in), .vertices_out(vout[0]),
    .area_out(area_o[0]), .bbox_min_out(bmin_o[0]), .bbox_max_out(bmax_o[0]),
`ifdef TRIANGLE_SETUP_STATS_EN
    .culled_zero_out(st_zero[0]), .culled_back_out(st_back[0]),
    .culled_offscreen_out(st_off[0]), .emitted_out(st_emit[0]),
`endif
    .flipped_out(flip_o[0])
  );

  triangle_setup #(.CULL_BACK(0)) u_dut_nc (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .tri_valid_in(tri_valid_in), .tri_ready_out(rdy_o[1]), .vertices_in(vertices_in),
    .tri_valid_out(vld_o[1]), .tri_ready_in(tri_ready_in), .vertices_out(vout[1]),
    .area_out(area_o[1]), .bbox_min_out(bmin_o[1]), .bbox_max_out(bmax_o[1]),
`ifdef TRIANGLE_SETUP_STATS_EN
    .culled_zero_out(st_zero[1]), .culled_back_out(st_back[1]),
    .culled_offscreen_out(st_off[1]), .emitted_out(st_emit[1]),
`endif
    .flipped_out(flip_o[1])
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tri_t mk(int x0, int y0, int x1, int y1, int x2, int y2);
    tri_t t;
    t[0][0] = 17'(x0); t[0][1] = 17'(y0);
    t[1][0] = 17'(x1); t[1][1] = 17'(y1);
    t[2][0] = 17'(x2); t[2][1] = 17'(y2);
    return t;
  endfunction

  function automatic tri_t pat(int k);
    return mk(k, 0, k, 10, k + 10, 0);
  endfunction

  // Reference: signed doubled area, cull decisions, winding swap, screen clamp.
  function automatic void model(input tri_t v, input bit cull, output bit drop, output setup_t e);
    longint x [3];
    longint y [3];
    longint a, mnx, mny, mxx, mxy;
    for (int i = 0; i < 3; i++) begin
      x[i] = longint'(v[i][0]);
      y[i] = longint'(v[i][1]);
    end
    a = (x[2] - x[0]) * (y[1] - y[0]) - (x[1] - x[0]) * (y[2] - y[0]);
    mnx = x[0]; mxx = x[0]; mny = y[0]; mxy = y[0];
    for (int i = 1; i < 3; i++) begin
      if (x[i] < mnx) mnx = x[i];
      if (x[i] > mxx) mxx = x[i];
      if (y[i] < mny) mny = y[i];
      if (y[i] > mxy) mxy = y[i];
    end
    drop = (a == 0) || (a < 0 && cull) || (mnx > SW - 1) || (mny > SH - 1);
    e.area = 34'((a < 0) ? -a : a);
    e.flipped = (a < 0);
    e.vertices = v;
    if (a < 0) begin
      e.vertices[1] = v[2];
      e.vertices[2] = v[1];
    end
    e.bbox_min[0] = 17'((mnx > SW - 1) ? SW - 1 : mnx);
    e.bbox_min[1] = 17'((mny > SH - 1) ? SH - 1 : mny);
    e.bbox_max[0] = 17'((mxx > SW - 1) ? SW - 1 : mxx);
    e.bbox_max[1] = 17'((mxy > SH - 1) ? SH - 1 : mxy);
  endfunction

  function automatic tri_t rand_tri();
    tri_t t;
    int sel;
    sel = $urandom_range(0, 15);
    for (int i = 0; i < 3; i++) begin
      t[i][0] = 17'($urandom_range(0, 360));
      t[i][1] = 17'($urandom_range(0, 270));
    end
    if (sel == 0) t[$urandom_range(0, 2)][0] = 17'h1FFFF;
    if (sel == 1) t[2] = t[0];
    if (sel == 2) begin
      t = mk(0, 0, 0, 0, 0, 0);
      t[1][0] = 17'h1FFFF;
      t[2][1] = 17'h1FFFF;
    end
    if (sel == 3) for (int i = 0; i < 3; i++) t[i][0] = t[i][0] + 17'd330;
    return t;
  endfunction

  // Scoreboard: push expectations at accept, compare at pop; flush on reset.
  always @(negedge clk_in) begin
    setup_t e;
    bit drop;
    if (!rst_n_in) begin
      sb0.delete();
      sb1.delete();
      acc_cnt[0] = 0;
      acc_cnt[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (tri_valid_in && rdy_o[d]) begin
          acc_cnt[d]++;
          model(vertices_in, d == 0, drop, e);
          if (!drop) begin
            if (d == 0) sb0.push_back(e);
            else        sb1.push_back(e);
          end
        end
        if (vld_o[d] && tri_ready_in) begin
          if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            chk($sformatf("d%0d_spurious_output", d), 1, 0);
          end else begin
            if (d == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            chk($sformatf("d%0d_vertices", d), vout[d], e.vertices);
            chk($sformatf("d%0d_area", d), area_o[d], e.area);
            chk($sformatf("d%0d_bbox_min", d), bmin_o[d], e.bbox_min);
            chk($sformatf("d%0d_bbox_max", d), bmax_o[d], e.bbox_max);
            chk($sformatf("d%0d_flipped", d), flip_o[d], e.flipped);
          end
        end
      end
    end
  end

  task automatic send_tri(input tri_t t);
    int w = 0;
    bit ok = 0;
    tri_valid_in = 1'b1;
    vertices_in = t;
    while (!ok && w < 200) begin
      @(negedge clk_in);
      w++;
      ok = rdy_o[0] || rdy_o[1];
      @(posedge clk_in); #1;
    end
    tri_valid_in = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk_in); #1;
    rst_n_in = 1'b0;
    tri_valid_in = 1'b0;
    repeat (n) begin
      @(negedge clk_in);
      chk("rst_ready", rdy_o[0], 0);
      chk("rst_valid", vld_o[0], 0);
      chk("rst_area", area_o[0], 0);
      chk("rst_vertices", vout[0], 0);
      @(posedge clk_in);
    end
    #1 rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("rst_release_ready_a", rdy_o[0], 1);
    chk("rst_release_ready_b", rdy_o[1], 1);
    @(posedge clk_in); #1;
  endtask

  task automatic drain(input string tag);
    int c = 0;
    tri_ready_in = 1'b1;
    while ((sb0.size() != 0 || sb1.size() != 0 || c < 12) && c < 300) begin
      @(negedge clk_in);
      c++;
    end
    chk({tag, "_drained"}, sb0.size() + sb1.size(), 0);
    @(posedge clk_in); #1;
  endtask

  task automatic lat_check(input string tag);
    int lat = 0;
    tri_ready_in = 1'b1;
    send_tri(mk(0, 0, 0, 10, 10, 0));
    do begin
      @(negedge clk_in);
      lat++;
    end while (!vld_o[0] && lat < 40);
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_area"}, area_o[0], 100);
    chk({tag, "_flipped"}, flip_o[0], 0);
    chk({tag, "_bbox_min"}, bmin_o[0], 0);
    chk({tag, "_bbox_max"}, bmax_o[0], {17'd10, 17'd10});
    @(posedge clk_in); #1;
  endtask

  // Keep offering a stream of triangles until 'target' accepts or the cycle budget runs out.
  task automatic stream(input int target, input int budget, output int got);
    int k = 0;
    bit acc;
    tri_valid_in = 1'b1;
    vertices_in = pat(0);
    repeat (budget) begin
      @(negedge clk_in);
      acc = rdy_o[0] || rdy_o[1];
      @(posedge clk_in); #1;
      if (acc) begin
        k++;
        vertices_in = pat(k);
      end
      if (k == target) break;
    end
    tri_valid_in = 1'b0;
    got = k;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base0, base1, got, seen, n, cyc;
    bit acc;

    do_reset(3);

    // Basic CCW triangle and first-result latency.
    lat_check("ccw");
    drain("ccw");

    // Back-facing, collinear, off-screen and clamped cases.
    tri_ready_in = 1'b1;
    send_tri(mk(0, 0, 10, 0, 0, 10));
    send_tri(mk(0, 0, 5, 5, 10, 10));
    send_tri(mk(400, 5, 410, 5, 400, 20));
    send_tri(mk(300, 200, 400, 200, 300, 300));
    send_tri(mk(0, 0, 131071, 0, 0, 131071));
    drain("directed");

    // Downstream stalled: exactly FIFO_DEPTH triangles accepted, then ready drops.
    tri_ready_in = 1'b0;
    base0 = acc_cnt[0];
    base1 = acc_cnt[1];
    stream(100, 30, got);
    chk("bp_accepts_a", acc_cnt[0] - base0, 8);
    chk("bp_accepts_b", acc_cnt[1] - base1, 8);
    chk("bp_ready_low_a", rdy_o[0], 0);
    chk("bp_ready_low_b", rdy_o[1], 0);
    drain("bp");

    // Random traffic with random valid/ready.
    n = 0;
    cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      if (!tri_valid_in && $urandom_range(0, 3) != 0) begin
        tri_valid_in = 1'b1;
        vertices_in = rand_tri();
      end
      tri_ready_in = ($urandom_range(0, 3) != 0);
      @(negedge clk_in);
      acc = tri_valid_in && (rdy_o[0] || rdy_o[1]);
      @(posedge clk_in); #1;
      cyc++;
      if (acc) begin
        n++;
        tri_valid_in = 1'b0;
      end
    end
    tri_valid_in = 1'b0;
    chk("rand_count", n, 1000);
    drain("rand");

    // Reset with triangles both queued and in flight.
    tri_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) send_tri(pat(k));
    repeat (10) @(posedge clk_in);
    #1;
    stream(5, 20, got);
    chk("mid_stream_accepts", got, 5);
    do_reset(1);
    tri_ready_in = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk_in);
      if (vld_o[0] || vld_o[1]) seen++;
    end
    chk("post_reset_quiet", seen, 0);
    @(posedge clk_in); #1;
    lat_check("post_reset");
    drain("final");

`ifdef TRIANGLE_SETUP_STATS_EN
    chk("stats_sum_a", st_zero[0] + st_back[0] + st_off[0] + st_emit[0], acc_cnt[0]);
    chk("stats_sum_b", st_zero[1] + st_back[1] + st_off[1] + st_emit[1], acc_cnt[1]);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
